// File: rtl/pipe_hazard_if.sv
// Control/status bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_branch_taken;
  logic             mem_req, mem_ready, irq, eret;
  logic             if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en;
  logic             if2id_flush, id2ex_flush, irq_take, mem_err;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_branch_taken,
           mem_req, mem_ready, irq, eret,
    input  if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en, if2id_flush, id2ex_flush,
           pc_sel, irq_take, mem_err, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_branch_taken,
           mem_req, mem_ready, irq, eret,
    output if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en, if2id_flush, id2ex_flush,
           pc_sel, irq_take, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: stage enables, flushes, next-PC select, memory-wait/interrupt FSM.
// Optional macro PIPE_PERF_CNT_EN enables the saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  pipe_hazard_if.slave hz
);
  typedef enum logic {RUN, MEMWAIT} state_t;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state, stateNxt;
  logic [TMO_W-1:0] tmoCnt, tmoNxt;
  logic             irqMask, irqMaskNxt;
  logic             memStart, freeze, timeout, loadUse, irqReq;
  logic             ifEn, if2idEn, id2exEn, ex2memEn, mem2wbEn;
  logic             if2idFlush, id2exFlush, irqTake, memErr;
  logic [1:0]       pcSel;
  logic [CNT_W-1:0] stallCnt;

  assign memStart = (state == RUN) && hz.mem_req && !hz.mem_ready;
  assign timeout  = (state == MEMWAIT) && !hz.mem_ready && (tmoCnt == TMO_LAST);
  assign freeze   = memStart || ((state == MEMWAIT) && !hz.mem_ready && (tmoCnt < TMO_LAST));
  assign loadUse  = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
  assign irqReq   = hz.irq && !irqMask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      tmoCnt  <= '0;
      irqMask <= 1'b0;
    end else begin
      state   <= stateNxt;
      tmoCnt  <= tmoNxt;
      irqMask <= irqMaskNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    tmoNxt   = tmoCnt;
    case (state)
      RUN:     if (memStart) begin stateNxt = MEMWAIT; tmoNxt = '0; end
      MEMWAIT: if (hz.mem_ready || timeout) stateNxt = RUN;
               else tmoNxt = tmoCnt + 1'b1;
      default: stateNxt = RUN;
    endcase
    // A take in the same cycle as eret keeps the mask set.
    irqMaskNxt = irqMask;
    if (irqTake)      irqMaskNxt = 1'b1;
    else if (hz.eret) irqMaskNxt = 1'b0;
  end

  always_comb begin
    ifEn = 1'b0; if2idEn = 1'b0; id2exEn = 1'b0; ex2memEn = 1'b0; mem2wbEn = 1'b0;
    if2idFlush = 1'b0; id2exFlush = 1'b0; pcSel = 2'd0; irqTake = 1'b0; memErr = 1'b0;
    if (rst_n && !freeze) begin
      ifEn = 1'b1; if2idEn = 1'b1; id2exEn = 1'b1; ex2memEn = 1'b1; mem2wbEn = 1'b1;
      memErr = timeout;
      // Branch beats irq so its target survives; the irq is taken the next cycle.
      if (hz.ex_branch_taken) begin
        pcSel = 2'd1; if2idFlush = 1'b1; id2exFlush = 1'b1;
      end else if (irqReq) begin
        pcSel = 2'd3; irqTake = 1'b1; if2idFlush = 1'b1; id2exFlush = 1'b1;
      end else if (loadUse) begin
        ifEn = 1'b0; if2idEn = 1'b0; id2exFlush = 1'b1;
      end else if (hz.id_jump) begin
        pcSel = 2'd2; if2idFlush = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stallCnt <= '0;
    else if (!ifEn && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  end
`else
  assign stallCnt = '0;
`endif

  assign hz.if_en       = ifEn;
  assign hz.if2id_en    = if2idEn;
  assign hz.id2ex_en    = id2exEn;
  assign hz.ex2mem_en   = ex2memEn;
  assign hz.mem2wb_en   = mem2wbEn;
  assign hz.if2id_flush = if2idFlush;
  assign hz.id2ex_flush = id2exFlush;
  assign hz.pc_sel      = pcSel;
  assign hz.irq_take    = irqTake;
  assign hz.mem_err     = memErr;
  assign hz.stall_cnt   = stallCnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: constant-expectation table, multi-cycle corner sequences, random vs. model.
module tb_pipe_hazard_ctrl;
  localparam int MT = 4;

  typedef struct packed {
    logic [4:0] idRs, idRt, exRt;
    logic usesRs, usesRt, jump, memread, br, req, rdy, irq, eret;
  } inp_t;
  typedef struct packed {
    logic ifEn, if2idEn, id2exEn, ex2memEn, mem2wbEn, if2idFlush, id2exFlush;
    logic [1:0] pcSel;
    logic irqTake, memErr;
  } outs_t;
  typedef struct { inp_t i; outs_t o; } vec_t;

  localparam outs_t DEF = 11'b11111_00_00_00;
  localparam outs_t LU  = 11'b00111_01_00_00;
  localparam outs_t BR  = 11'b11111_11_01_00;
  localparam outs_t JMP = 11'b11111_10_10_00;
  localparam outs_t IRQ = 11'b11111_11_11_10;
  localparam outs_t FRZ = 11'b00000_00_00_00;
  localparam outs_t TMO = 11'b11111_00_00_01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;

  // model state: waiting flag, cycles since the request cycle, irq mask, stall count
  bit          mInWait, mMask;
  int          mAge;
  logic [31:0] mStall;

  pipe_hazard_if #(.CNT_W(32)) hz();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .TMO_W(3), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  always #5 clk = ~clk;

  function automatic inp_t mk(input logic [4:0] rs, rt, ex, input logic [8:0] f);
    inp_t v;
    v.idRs = rs; v.idRt = rt; v.exRt = ex;
    {v.usesRs, v.usesRt, v.jump, v.memread, v.br, v.req, v.rdy, v.irq, v.eret} = f;
    return v;
  endfunction

  task automatic apply(input inp_t v);
    hz.id_rs = v.idRs; hz.id_rt = v.idRt; hz.ex_rt = v.exRt;
    hz.id_uses_rs = v.usesRs; hz.id_uses_rt = v.usesRt; hz.id_jump = v.jump;
    hz.ex_memread = v.memread; hz.ex_branch_taken = v.br;
    hz.mem_req = v.req; hz.mem_ready = v.rdy; hz.irq = v.irq; hz.eret = v.eret;
  endtask

  function automatic outs_t dutOuts();
    return outs_t'({hz.if_en, hz.if2id_en, hz.id2ex_en, hz.ex2mem_en, hz.mem2wb_en,
                    hz.if2id_flush, hz.id2ex_flush, hz.pc_sel, hz.irq_take, hz.mem_err});
  endfunction

  function automatic outs_t modelOut();
    outs_t o;
    bit fr, hazard;
    o = FRZ;
    if (!rst_n) return o;
    if (!mInWait) fr = hz.mem_req && !hz.mem_ready;
    else          fr = !hz.mem_ready && (mAge < MT);
    if (fr) return o;
    o = DEF;
    o.memErr = mInWait && !hz.mem_ready && (mAge == MT);
    hazard = hz.ex_memread && hz.ex_rt != 0 &&
             ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) || (hz.id_uses_rt && hz.id_rt == hz.ex_rt));
    if (hz.ex_branch_taken)   o = BR;
    else if (hz.irq && !mMask) o = IRQ;
    else if (hazard)          o = LU;
    else if (hz.id_jump)      o = JMP;
    if (hz.ex_branch_taken || (hz.irq && !mMask) || hazard || hz.id_jump)
      o.memErr = mInWait && !hz.mem_ready && (mAge == MT);
    return o;
  endfunction

  task automatic modelReset();
    mInWait = 0; mAge = 0; mMask = 0; mStall = '0;
  endtask

  task automatic modelStep(input outs_t o);
    if (!mInWait) begin
      if (hz.mem_req && !hz.mem_ready) begin mInWait = 1; mAge = 1; end
    end else if (hz.mem_ready || mAge == MT) mInWait = 0;
    else mAge++;
    if (o.irqTake)      mMask = 1;
    else if (hz.eret)   mMask = 0;
`ifdef PIPE_PERF_CNT_EN
    if (!o.ifEn && mStall != '1) mStall = mStall + 1;
`endif
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inputs are set just after posedge; outputs compared on the negedge
  task automatic tick(input string nm, input bit useTab, input outs_t tabExp);
    outs_t act, exp;
    @(negedge clk);
    act = dutOuts();
    exp = modelOut();
    chk({nm, "/model"}, act, exp);
    chk({nm, "/stall"}, hz.stall_cnt, mStall);
    if (useTab) chk({nm, "/const"}, act, tabExp);
    modelStep(exp);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] s0;
    logic [31:0] expDelta;
    modelReset();
    apply(mk(0, 0, 0, 9'b0));
    #2;
    chk("reset_outs", dutOuts(), FRZ);
    chk("reset_stall", hz.stall_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // flags: usesRs usesRt jump memread br req rdy irq eret
    tbl.push_back('{mk(0, 0, 0, 9'b000000000), DEF});
    tbl.push_back('{mk(5, 0, 5, 9'b100100000), LU});
    tbl.push_back('{mk(0, 7, 7, 9'b010100000), LU});
    tbl.push_back('{mk(0, 0, 0, 9'b110100000), DEF});
    tbl.push_back('{mk(5, 0, 5, 9'b000100000), DEF});
    tbl.push_back('{mk(5, 6, 5, 9'b010100000), DEF});
    tbl.push_back('{mk(0, 0, 0, 9'b001010000), BR});
    tbl.push_back('{mk(0, 0, 0, 9'b001000000), JMP});
    tbl.push_back('{mk(9, 0, 9, 9'b101100000), LU});
    tbl.push_back('{mk(0, 0, 0, 9'b000001100), DEF});
    tbl.push_back('{mk(0, 0, 0, 9'b000010010), BR});
    tbl.push_back('{mk(0, 0, 0, 9'b000000010), IRQ});
    tbl.push_back('{mk(0, 0, 0, 9'b000000010), DEF});
    tbl.push_back('{mk(0, 0, 0, 9'b000000001), DEF});
    tbl.push_back('{mk(0, 0, 0, 9'b000000011), IRQ});
    tbl.push_back('{mk(0, 0, 0, 9'b000000010), DEF});
    tbl.push_back('{mk(0, 0, 0, 9'b000000011), DEF});
    tbl.push_back('{mk(5, 0, 5, 9'b100100010), IRQ});
    tbl.push_back('{mk(0, 0, 0, 9'b000000001), DEF});
    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      tick($sformatf("tbl%0d", k), 1'b1, tbl[k].o);
    end

    // memory wait: three frozen cycles (branch/irq masked), then release on ready
`ifdef PIPE_PERF_CNT_EN
    expDelta = 3;
`else
    expDelta = 0;
`endif
    s0 = mStall;
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 0, 0, 9'b000011010));
      tick($sformatf("wait%0d", k), 1'b1, FRZ);
    end
    apply(mk(0, 0, 0, 9'b000011100));
    tick("wait_release", 1'b1, BR);
    chk("wait_stall_delta", hz.stall_cnt, s0 + expDelta);
    apply(mk(0, 0, 0, 9'b0));
    tick("wait_idle", 1'b1, DEF);

    // timeout: request held, ready never comes
    for (int k = 0; k < MT; k++) begin
      apply(mk(0, 0, 0, 9'b000001000));
      tick($sformatf("tmo%0d", k), 1'b1, FRZ);
    end
    tick("tmo_err", 1'b1, TMO);
    apply(mk(0, 0, 0, 9'b0));
    tick("tmo_run", 1'b1, DEF);

    // asynchronous reset while in the wait state
    apply(mk(0, 0, 0, 9'b000001000));
    tick("rst_wait0", 1'b1, FRZ);
    tick("rst_wait1", 1'b1, FRZ);
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("rst_mid_outs", dutOuts(), FRZ);
    chk("rst_mid_stall", hz.stall_cnt, 0);
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 9'b0));
    rst_n = 1'b1;
    tick("rst_after", 1'b1, DEF);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      inp_t v;
      v.idRs = 5'($urandom_range(0, 3)); v.idRt = 5'($urandom_range(0, 3));
      v.exRt = 5'($urandom_range(0, 3));
      v.usesRs = 1'($urandom_range(0, 1)); v.usesRt = 1'($urandom_range(0, 1));
      v.jump = ($urandom_range(0, 5) == 0); v.memread = ($urandom_range(0, 2) == 0);
      v.br = ($urandom_range(0, 5) == 0); v.req = ($urandom_range(0, 2) == 0);
      v.rdy = ($urandom_range(0, 3) != 0); v.irq = ($urandom_range(0, 7) == 0);
      v.eret = ($urandom_range(0, 7) == 0);
      if (k % 150 == 100) v.rdy = 1'b0;
      apply(v);
      tick($sformatf("rnd%0d", k), 1'b0, FRZ);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
